// File: rtl/sincos_req_sched.sv
// Two-requester round-robin scheduler feeding sin/cos issue passes to the decode stage.
// Latency: issue slot valid 1 cycle after a request is accepted; one IDLE bubble after each final pass.
// Backpressure: i_ready low freezes the issue slot and blocks new grants; requesters see it only via o_reqN_ready.
//
// Configuration macro: SCHED_SINCOS_BOTH_EN
//   defined   : op=11 issues a sin pass (ISSUE1) followed by a cos pass (ISSUE2).
//   undefined : op=11 issues a single sin pass with o_last=1; ISSUE2 is never entered.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_reqN_valid / o_reqN_ready    request handshake for requester N (N=0,1); ready is combinational
//   i_reqN_exp/frac/op             operand and operation select of requester N
//   o_valid / i_ready              issue-slot handshake towards the pre-map/decode stage
//   o_exp, o_frac, o_tag           held operand and requester index of the issued pass
//   o_sincos_proced                0 = sin pass, 1 = cos pass
//   o_X_ZERO_FLAG                  issued fraction is exactly zero
//   o_last                         final pass of the current request
//   o_busy                         scheduler not idle
module sincos_req_sched #(
    parameter int RR_INIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [7:0]  i_req0_exp,
    input  logic [31:0] i_req0_frac,
    input  logic [1:0]  i_req0_op,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [7:0]  i_req1_exp,
    input  logic [31:0] i_req1_frac,
    input  logic [1:0]  i_req1_op,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_exp,
    output logic [31:0] o_frac,
    output logic        o_sincos_proced,
    output logic        o_X_ZERO_FLAG,
    output logic        o_tag,
    output logic        o_last,
    output logic        o_busy
);

`ifdef SCHED_SINCOS_BOTH_EN
    localparam logic BOTH_EN = 1'b1;
`else
    localparam logic BOTH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE1 = 2'd1,
        ISSUE2 = 2'd2
    } state_t;

    state_t      state;
    logic        prio;          // requester that wins when both are valid

    // Hold register: captured on grant, drives the issue outputs for every pass.
    logic [7:0]  hold_exp;
    logic [31:0] hold_frac;
    logic [1:0]  hold_op;
    logic        hold_tag;
    logic        hold_zero;

    // Registered issue-slot control outputs.
    logic        valid_q;
    logic        proced_q;
    logic        last_q;
    logic        busy_q;

    // Grant selection (only meaningful in IDLE).
    logic        grant0;
    logic        grant1;
    logic        grant_any;
    logic [7:0]  sel_exp;
    logic [31:0] sel_frac;
    logic [1:0]  sel_op;
    logic        sel_two_pass;
    logic        hold_two_pass;

    assign grant0    = (state == IDLE) && i_req0_valid && (!i_req1_valid || !prio);
    assign grant1    = (state == IDLE) && i_req1_valid && (!i_req0_valid ||  prio);
    assign grant_any = grant0 || grant1;

    // Ready is masked by reset so a requester never believes it was consumed
    // on an edge where reset wins over the grant.
    assign o_req0_ready = i_rst_n && grant0;
    assign o_req1_ready = i_rst_n && grant1;

    assign sel_exp  = grant1 ? i_req1_exp  : i_req0_exp;
    assign sel_frac = grant1 ? i_req1_frac : i_req0_frac;
    assign sel_op   = grant1 ? i_req1_op   : i_req0_op;

    // A second (cos) pass exists only for op=11 with the dual-pass build.
    assign sel_two_pass  = BOTH_EN && (sel_op  == 2'b11);
    assign hold_two_pass = BOTH_EN && (hold_op == 2'b11);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            prio      <= (RR_INIT != 0);
            hold_exp  <= 8'd0;
            hold_frac <= 32'd0;
            hold_op   <= 2'b00;
            hold_tag  <= 1'b0;
            hold_zero <= 1'b0;
            valid_q   <= 1'b0;
            proced_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        hold_exp  <= sel_exp;
                        hold_frac <= sel_frac;
                        hold_op   <= sel_op;
                        hold_tag  <= grant1;
                        hold_zero <= (sel_frac == 32'd0);
                        // Priority moves to whoever did not win this grant.
                        prio      <= ~grant1;
                        // op=00 is consumed silently; stay idle.
                        if (sel_op != 2'b00) begin
                            state    <= ISSUE1;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            proced_q <= ~sel_op[0];
                            last_q   <= ~sel_two_pass;
                        end
                    end
                end

                ISSUE1: begin
                    if (i_ready) begin
                        if (hold_two_pass) begin
                            state    <= ISSUE2;
                            proced_q <= 1'b1;
                            last_q   <= 1'b1;
                        end else begin
                            // Returning to IDLE gives the single bubble cycle
                            // in which the next grant is taken.
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                ISSUE2: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid         = valid_q;
    assign o_exp           = hold_exp;
    assign o_frac          = hold_frac;
    assign o_tag           = hold_tag;
    assign o_X_ZERO_FLAG   = hold_zero;
    assign o_sincos_proced = proced_q;
    assign o_last          = last_q;
    assign o_busy          = busy_q;

endmodule
